// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the multiplier/divider pair:
// the FSM state encoding, the default operand width and the iteration-counter sizing.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 2;

    // The counter must reach 2*WIDTH-1; the extra bit leaves headroom.
    function automatic int cnt_width(input int width);
        return $clog2(2 * width) + 1;
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the partial remainder left, bring in
// the next dividend bit, then subtract the divisor when the result is large enough.
module div_step
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;

    // The incoming remainder is always below the divisor, so after the subtract
    // the true difference fits WIDTH bits and modular WIDTH-bit arithmetic is exact.
    always_comb begin
        shifted = {rem_i, bit_i};
        qbit_o  = (shifted >= {1'b0, divisor_i});
        rem_o   = qbit_o ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, framed by a start/busy/done handshake.
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero
);

    localparam int DW    = 2 * WIDTH;
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DW - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      dvd_q, dvd_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic [WIDTH-1:0]   prem_q, prem_d;
    logic [DW-1:0]      qacc_q, qacc_d;
    logic [DW-1:0]      quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   step_rem;
    logic               step_qbit;
    logic               accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (prem_q),
        .bit_i     (dvd_q[DW-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        prem_d  = prem_q;
        qacc_d  = qacc_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        accept  = start && (state_q != ST_RUN);

        case (state_q)
            ST_RUN: begin
                prem_d = step_rem;
                dvd_d  = {dvd_q[DW-2:0], 1'b0};
                qacc_d = {qacc_q[DW-2:0], step_qbit};
                cnt_d  = cnt_q + CNT_W'(1);
                // Result ports change only here, so nothing partial is ever visible.
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                    quot_d  = {qacc_q[DW-2:0], step_qbit};
                    rem_d   = step_rem;
                    dbz_d   = 1'b0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: ;
        endcase

        // Accepting from DONE as well as IDLE gives back-to-back operation.
        if (accept) begin
            dvd_d  = dividend;
            dsr_d  = divisor;
            cnt_d  = '0;
            prem_d = '0;
            qacc_d = '0;
            if (divisor == '0) begin
                state_d = ST_DONE;
                quot_d  = '1;
                rem_d   = '0;
                dbz_d   = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            qacc_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            prem_q  <= prem_d;
            qacc_q  <= qacc_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider at WIDTH=2, 4 and 8 against a plain-arithmetic division model.
module tb_seq_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       st2, b2, d2, z2;
    logic [3:0] dvd2, q2;
    logic [1:0] dsr2, r2;

    logic       st4, b4, d4, z4;
    logic [7:0] dvd4, q4;
    logic [3:0] dsr4, r4;

    logic        st8, b8, d8, z8;
    logic [15:0] dvd8, q8;
    logic [7:0]  dsr8, r8;

    int n_cmp = 0;
    int n_bad = 0;

    seq_divider #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(st2), .dividend(dvd2), .divisor(dsr2),
        .quotient(q2), .remainder(r2), .busy(b2), .done(d2), .div_by_zero(z2)
    );
    seq_divider #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(st4), .dividend(dvd4), .divisor(dsr4),
        .quotient(q4), .remainder(r4), .busy(b4), .done(d4), .div_by_zero(z4)
    );
    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .dividend(dvd8), .divisor(dsr8),
        .quotient(q8), .remainder(r8), .busy(b8), .done(d8), .div_by_zero(z8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division; divide-by-zero yields all-ones / zero.
    function automatic void ref_div(input int a, input int b, input int width,
                                    output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << (2 * width)) - 1;
            r = 0;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endfunction

    // Start one WIDTH=2 operation; lat is the cycle (start cycle = 0) in which done is seen.
    task automatic op2(input logic [3:0] a, input logic [1:0] b, output int lat, output int bcnt);
        st2 = 1'b1; dvd2 = a; dsr2 = b;
        tick();
        st2 = 1'b0; dvd2 = 4'($urandom); dsr2 = 2'($urandom);
        lat = 1; bcnt = 0;
        while (!d2 && lat < 50) begin
            if (b2) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic op4(input logic [7:0] a, input logic [3:0] b, output int lat);
        st4 = 1'b1; dvd4 = a; dsr4 = b;
        tick();
        st4 = 1'b0; dvd4 = 8'($urandom); dsr4 = 4'($urandom);
        lat = 1;
        while (!d4 && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (q2 !== 4'd0) begin n_bad++; $display("FAIL reset_quotient: got %0d expected 0", q2); end
        n_cmp++; if (r2 !== 2'd0) begin n_bad++; $display("FAIL reset_remainder: got %0d expected 0", r2); end
        n_cmp++; if ({b2, d2, z2} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b expected 000", {b2, d2, z2}); end
        n_cmp++; if ({b4, d4, b8, d8, z8, q8} !== '0) begin n_bad++; $display("FAIL reset_wide: got %0h expected 0", {b4, d4, b8, d8, z8, q8}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, bcnt;
        op2(4'd6, 2'd3, lat, bcnt);
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL basic_latency: got %0d expected 5", lat); end
        n_cmp++; if (bcnt !== 4) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d expected 4", bcnt); end
        n_cmp++; if (q2 !== 4'd2) begin n_bad++; $display("FAIL basic_quotient: got %0d expected 2", q2); end
        n_cmp++; if (r2 !== 2'd0) begin n_bad++; $display("FAIL basic_remainder: got %0d expected 0", r2); end
        n_cmp++; if ({b2, z2} !== 2'b00) begin n_bad++; $display("FAIL basic_busy_dbz_at_done: got %b expected 00", {b2, z2}); end
        tick();
        n_cmp++; if (d2 !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b expected 0", d2); end
        n_cmp++; if (q2 !== 4'd2) begin n_bad++; $display("FAIL basic_hold: got %0d expected 2", q2); end
    endtask

    task automatic test_div_zero();
        int lat, bcnt;
        op2(4'd9, 2'd0, lat, bcnt);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL dbz_latency: got %0d expected 1", lat); end
        n_cmp++; if (bcnt !== 0) begin n_bad++; $display("FAIL dbz_busy: got %0d expected 0", bcnt); end
        n_cmp++; if (q2 !== 4'd15) begin n_bad++; $display("FAIL dbz_quotient: got %0d expected 15", q2); end
        n_cmp++; if (r2 !== 2'd0) begin n_bad++; $display("FAIL dbz_remainder: got %0d expected 0", r2); end
        n_cmp++; if (z2 !== 1'b1) begin n_bad++; $display("FAIL dbz_flag: got %b expected 1", z2); end
        tick();
        n_cmp++; if (z2 !== 1'b1) begin n_bad++; $display("FAIL dbz_flag_held: got %b expected 1", z2); end
    endtask

    task automatic test_sequence();
        int lat, bcnt, eq, er, ez;
        int av[2] = '{15, 0};
        int bv[2] = '{2, 3};
        for (int i = 0; i < 2; i++) begin
            ref_div(av[i], bv[i], 2, eq, er, ez);
            op2(4'(av[i]), 2'(bv[i]), lat, bcnt);
            n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL seq_latency[%0d]: got %0d expected 5", i, lat); end
            n_cmp++; if (q2 !== 4'(eq)) begin n_bad++; $display("FAIL seq_quotient[%0d]: got %0d expected %0d", i, q2, eq); end
            n_cmp++; if (r2 !== 2'(er)) begin n_bad++; $display("FAIL seq_remainder[%0d]: got %0d expected %0d", i, r2, er); end
            n_cmp++; if (z2 !== ez[0]) begin n_bad++; $display("FAIL seq_dbz[%0d]: got %b expected %0d", i, z2, ez); end
        end
        tick();
    endtask

    task automatic test_ignored_start();
        int lat;
        st2 = 1'b1; dvd2 = 4'd6; dsr2 = 2'd3;
        tick();
        st2 = 1'b0;
        tick();
        st2 = 1'b1; dvd2 = 4'd15; dsr2 = 2'd1;
        tick();
        st2 = 1'b0; dvd2 = 4'd13; dsr2 = 2'd2;
        n_cmp++; if (b2 !== 1'b1) begin n_bad++; $display("FAIL ignored_busy: got %b expected 1", b2); end
        lat = 3;
        while (!d2 && lat < 50) begin
            tick();
            lat++;
        end
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL ignored_latency: got %0d expected 5", lat); end
        n_cmp++; if (q2 !== 4'd2) begin n_bad++; $display("FAIL ignored_quotient: got %0d expected 2", q2); end
        n_cmp++; if (r2 !== 2'd0) begin n_bad++; $display("FAIL ignored_remainder: got %0d expected 0", r2); end
        tick();
        n_cmp++; if ({b2, d2} !== 2'b00) begin n_bad++; $display("FAIL ignored_no_second_op: got %b expected 00", {b2, d2}); end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        st2 = 1'b1; dvd2 = 4'd15; dsr2 = 2'd2;
        tick();
        st2 = 1'b0;
        tick();
        n_cmp++; if (q2 !== 4'd2) begin n_bad++; $display("FAIL run_no_intermediate: got %0d expected 2", q2); end
        rst = 1'b1;
        tick();
        n_cmp++; if ({q2, r2} !== 6'd0) begin n_bad++; $display("FAIL midrst_results: got %0h expected 0", {q2, r2}); end
        n_cmp++; if ({b2, d2, z2} !== 3'b000) begin n_bad++; $display("FAIL midrst_flags: got %b expected 000", {b2, d2, z2}); end
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            tick();
            if (d2 || b2) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_aborted: got %0d active cycles expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        int cyc, c1;
        st8 = 1'b1; dvd8 = 16'd1000; dsr8 = 8'd7;
        tick();
        dvd8 = 16'd65535; dsr8 = 8'd255;
        cyc = 1;
        while (!d8 && cyc < 100) begin
            tick();
            cyc++;
        end
        c1 = cyc;
        n_cmp++; if (c1 !== 17) begin n_bad++; $display("FAIL b2b_first_latency: got %0d expected 17", c1); end
        n_cmp++; if (q8 !== 16'd142) begin n_bad++; $display("FAIL b2b_first_quotient: got %0d expected 142", q8); end
        n_cmp++; if (r8 !== 8'd6) begin n_bad++; $display("FAIL b2b_first_remainder: got %0d expected 6", r8); end
        tick();
        cyc++;
        st8 = 1'b0;
        n_cmp++; if ({b8, d8} !== 2'b10) begin n_bad++; $display("FAIL b2b_restart: got busy/done %b expected 10", {b8, d8}); end
        while (!d8 && cyc < 200) begin
            tick();
            cyc++;
        end
        n_cmp++; if (cyc - c1 !== 17) begin n_bad++; $display("FAIL b2b_spacing: got %0d expected 17", cyc - c1); end
        n_cmp++; if (q8 !== 16'd257) begin n_bad++; $display("FAIL b2b_second_quotient: got %0d expected 257", q8); end
        n_cmp++; if (r8 !== 8'd0) begin n_bad++; $display("FAIL b2b_second_remainder: got %0d expected 0", r8); end
        tick();
    endtask

    task automatic test_random();
        int lat, eq, er, ez;
        logic [7:0] a, b, prod;
        for (int i = 0; i < 500; i++) begin
            a = 8'($urandom_range(0, 15));
            b = 8'($urandom_range(1, 15));
            prod = a * b;
            op4(prod, b[3:0], lat);
            n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL rand_mul_latency[%0d]: got %0d expected 9", i, lat); end
            n_cmp++; if (q4 !== a) begin n_bad++; $display("FAIL rand_mul_quotient[%0d] %0d/%0d: got %0d expected %0d", i, prod, b, q4, a); end
            n_cmp++; if (r4 !== 4'd0) begin n_bad++; $display("FAIL rand_mul_remainder[%0d] %0d/%0d: got %0d expected 0", i, prod, b, r4); end
        end
        for (int i = 0; i < 100; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 15));
            ref_div(int'(a), int'(b), 4, eq, er, ez);
            op4(a, b[3:0], lat);
            n_cmp++; if (q4 !== 8'(eq) || r4 !== 4'(er) || z4 !== ez[0]) begin
                n_bad++;
                $display("FAIL rand_div[%0d] %0d/%0d: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%0d", i, a, b, q4, r4, z4, eq, er, ez);
            end
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        st2 = 1'b0; dvd2 = '0; dsr2 = '0;
        st4 = 1'b0; dvd4 = '0; dsr4 = '0;
        st8 = 1'b0; dvd8 = '0; dsr8 = '0;
        test_reset();
        test_basic();
        test_div_zero();
        test_sequence();
        test_ignored_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
